// File: rtl/frog_game_pkg.sv
// Purpose: shared constants, game-state encoding and car helper functions for
//          the frog/car grid game sequencer.
// Contents: grid geometry, field widths, button bit positions, game_state_t,
//           car_init_col(), car_moves_right(), car_lane_row(), col_step().
package frog_game_pkg;

    localparam int unsigned GRID_COLS      = 20;
    localparam int unsigned GRID_ROWS      = 15;
    localparam int unsigned FROG_START_COL = 10;
    localparam int unsigned FROG_START_ROW = 14;
    localparam int unsigned FIRST_LANE_ROW = 2;

    localparam int unsigned COL_W   = 5;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned SCORE_W = 7;
    localparam int unsigned BTN_W   = 5;

    // Bit positions inside the packed button vector
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_START = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    // Staggered start columns so the lanes do not line up vertically
    function automatic logic [COL_W-1:0] car_init_col(input int unsigned idx);
        return COL_W'((7 * idx) % GRID_COLS);
    endfunction

    // Even lanes run rightwards, odd lanes leftwards
    function automatic logic car_moves_right(input int unsigned idx);
        return (idx % 2) == 0;
    endfunction

    function automatic logic [ROW_W-1:0] car_lane_row(input int unsigned idx);
        return ROW_W'(FIRST_LANE_ROW + idx);
    endfunction

    // One column step with wrap at the 20-column border (not a 5-bit wrap)
    function automatic logic [COL_W-1:0] col_step(input logic [COL_W-1:0] col,
                                                  input logic             right);
        if (right) begin
            return (col == COL_W'(GRID_COLS - 1)) ? '0 : col + COL_W'(1);
        end
        return (col == '0) ? COL_W'(GRID_COLS - 1) : col - COL_W'(1);
    endfunction

endpackage

// File: rtl/frog_btn_edge.sv
// Purpose: registered rising-edge detector for a vector of debounced levels.
//          The first cycle after reset only primes the history register, so a
//          button already held through reset never produces an edge.
// Ports:  clk, rst (async active-high), level[WIDTH] in, rise[WIDTH] out
//         (one-cycle registered pulse per rising edge).
module frog_btn_edge #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;
    logic             armed;

    // History register plus registered edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= '0;
            armed <= 1'b0;
            rise  <= '0;
        end else begin
            prev  <= level;
            armed <= 1'b1;
            rise  <= armed ? (level & ~prev) : '0;
        end
    end

endmodule

// File: rtl/frog_game_ctrl.sv
// Purpose: game sequencer for the frog/car grid game. Owns frog position,
//          car columns, lives, score and the game state; all outputs are
//          registered and feed the VGA renderer as quasi-static coordinates.
// Ports:  clk, rst (async active-high), frame_tick (1/frame pulse),
//         btn_up/down/left/right/start (debounced levels),
//         frog_col[5], frog_row[4], car_x_bus[5*NUM_CARS], car_y_bus[4*NUM_CARS],
//         lives[2], score[7], game_state[2] (0 IDLE, 1 PLAY, 2 HIT, 3 OVER).
module frog_game_ctrl
    import frog_game_pkg::*;
#(
    parameter int unsigned NUM_CARS   = 11,
    parameter int unsigned CAR_DIV    = 8,
    parameter int unsigned HIT_FRAMES = 60,
    parameter int unsigned LIVES_INIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      btn_start,
    output logic [COL_W-1:0]          frog_col,
    output logic [ROW_W-1:0]          frog_row,
    output logic [COL_W*NUM_CARS-1:0] car_x_bus,
    output logic [ROW_W*NUM_CARS-1:0] car_y_bus,
    output logic [LIVES_W-1:0]        lives,
    output logic [SCORE_W-1:0]        score,
    output logic [1:0]                game_state
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned HIT_W = $clog2(HIT_FRAMES + 1);

    game_state_t      state;
    game_state_t      state_next;
    logic [BTN_W-1:0] btn_level;
    logic [BTN_W-1:0] btn_rise;

    logic game_init_c;
    logic frog_home_c;
    logic hit_enter_c;
    logic score_inc_c;
    logic play_run_c;
    logic car_step_c;
    logic match_c;

    logic             coll_q;
    logic             top_q;
    logic [DIV_W-1:0] car_div;
    logic [HIT_W-1:0] hit_cnt;
    logic [COL_W-1:0] car_x [NUM_CARS];

    assign btn_level = {btn_start, btn_right, btn_left, btn_down, btn_up};

    frog_btn_edge #(.WIDTH(BTN_W)) u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .level (btn_level),
        .rise  (btn_rise)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_next  = state;
        game_init_c = 1'b0;
        frog_home_c = 1'b0;
        hit_enter_c = 1'b0;
        score_inc_c = 1'b0;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (btn_rise[BTN_START]) begin
                    state_next  = ST_PLAY;
                    game_init_c = 1'b1;
                end
            end
            ST_PLAY: begin
                // Collision outranks reaching the top row
                if (coll_q) begin
                    state_next  = ST_HIT;
                    hit_enter_c = 1'b1;
                end else if (top_q) begin
                    score_inc_c = 1'b1;
                    frog_home_c = 1'b1;
                end
            end
            ST_HIT: begin
                if (frame_tick && (hit_cnt == HIT_W'(HIT_FRAMES - 1))) begin
                    frog_home_c = 1'b1;
                    state_next  = (lives == '0) ? ST_OVER : ST_PLAY;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        play_run_c = (state == ST_PLAY) && (state_next == ST_PLAY);
        car_step_c = play_run_c && frame_tick && (car_div == DIV_W'(CAR_DIV - 1));
    end

    assign game_state = state;

    // Frog position: reload on start/home, otherwise one prioritised clamped move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frog_col <= COL_W'(FROG_START_COL);
            frog_row <= ROW_W'(FROG_START_ROW);
        end else if (game_init_c || frog_home_c) begin
            frog_col <= COL_W'(FROG_START_COL);
            frog_row <= ROW_W'(FROG_START_ROW);
        end else if (play_run_c) begin
            if (btn_rise[BTN_UP]) begin
                if (frog_row != '0) frog_row <= frog_row - ROW_W'(1);
            end else if (btn_rise[BTN_DOWN]) begin
                if (frog_row != ROW_W'(GRID_ROWS - 1)) frog_row <= frog_row + ROW_W'(1);
            end else if (btn_rise[BTN_LEFT]) begin
                if (frog_col != '0) frog_col <= frog_col - COL_W'(1);
            end else if (btn_rise[BTN_RIGHT]) begin
                if (frog_col != COL_W'(GRID_COLS - 1)) frog_col <= frog_col + COL_W'(1);
            end
        end
    end

    // Car columns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CARS; i++) car_x[i] <= car_init_col(i);
        end else if (game_init_c) begin
            for (int unsigned i = 0; i < NUM_CARS; i++) car_x[i] <= car_init_col(i);
        end else if (car_step_c) begin
            for (int unsigned i = 0; i < NUM_CARS; i++) begin
                car_x[i] <= col_step(car_x[i], car_moves_right(i));
            end
        end
    end

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_car_bus
        assign car_x_bus[COL_W*g +: COL_W] = car_x[g];
        assign car_y_bus[ROW_W*g +: ROW_W] = car_lane_row(g);
    end

    // Frog against every car lane, OR-reduced
    always_comb begin
        match_c = 1'b0;
        for (int unsigned i = 0; i < NUM_CARS; i++) begin
            if ((frog_col == car_x[i]) && (frog_row == car_lane_row(i))) match_c = 1'b1;
        end
    end

    // Registered collision/top-row flags; cleared whenever the frog is reloaded
    // or play is suspended so a stale compare never fires after re-entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_q <= 1'b0;
            top_q  <= 1'b0;
        end else if (play_run_c && !frog_home_c) begin
            coll_q <= match_c;
            top_q  <= (frog_row == '0);
        end else begin
            coll_q <= 1'b0;
            top_q  <= 1'b0;
        end
    end

    // Car divider: counts frames in PLAY, wraps when the cars step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_div <= '0;
        end else if (game_init_c) begin
            car_div <= '0;
        end else if (play_run_c && frame_tick) begin
            car_div <= car_step_c ? '0 : car_div + DIV_W'(1);
        end
    end

    // Freeze-frame counter for HIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (hit_enter_c) begin
            hit_cnt <= '0;
        end else if ((state == ST_HIT) && frame_tick) begin
            hit_cnt <= hit_cnt + HIT_W'(1);
        end
    end

    // Lives (no underflow) and saturating score
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lives <= LIVES_W'(LIVES_INIT);
            score <= '0;
        end else if (game_init_c) begin
            lives <= LIVES_W'(LIVES_INIT);
            score <= '0;
        end else begin
            if (hit_enter_c && (lives != '0)) lives <= lives - LIVES_W'(1);
            if (score_inc_c && (score != '1)) score <= score + SCORE_W'(1);
        end
    end

endmodule
